// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers responses in order and
// presents them to Identify. Optional prefix pairing is enabled by `define FETCH_PREFIX_PAIR_EN.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [0:63] RESET_PC = 64'h0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   output logic                     o_mem_req,
   output logic [0:63]              o_mem_addr,
   input  logic                     i_mem_ack,
   input  logic                     i_mem_rvalid,
   input  logic [0:31]              i_mem_rdata,
   input  logic                     i_redirect,
   input  logic [0:63]              i_redirect_pc,
   output logic                     o_en,
   output logic [0:31]              o_instr,
   output logic [0:63]              o_instr_pc,
   output logic [0:31]              o_instr_suffix,
   output logic                     o_prefixed,
   input  logic                     i_stall,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

   logic [0:31]   instr_mem [DEPTH];
   logic [0:63]   pc_mem    [DEPTH];
   logic [PW-1:0] head, tail;
   cnt_t          count, inflight, drop;
   logic [0:63]   fetch_pc, resp_pc;

   logic          credit, ack_fire, resp, push, pop;
   logic [CW:0]   occupancy;
   cnt_t          pop_n, inflight_nxt;
   logic [1:0]    unused_rpc_lsbs;

   assign unused_rpc_lsbs = i_redirect_pc[62:63];

   // Credits cover both buffered words and outstanding requests, so a response always has a slot.
   assign occupancy = {1'b0, count} + {1'b0, inflight};
   assign credit    = occupancy < {1'b0, DEPTH_C};
   assign o_mem_req = !i_rst && !i_redirect && credit;
   // An ack in a redirect cycle is still a request the memory took; its response gets dropped.
   assign ack_fire  = !i_rst && i_mem_ack && credit;
   assign resp      = i_mem_rvalid && (inflight != '0);
   assign push      = resp && (drop == '0) && !i_redirect;
   assign pop       = o_en && !i_stall;

   assign inflight_nxt = inflight + cnt_t'(ack_fire) - cnt_t'(resp);
   assign o_mem_addr   = fetch_pc;
   assign o_count      = count;

   always_comb begin
      pop_n = '0;
      if (pop) begin
`ifdef FETCH_PREFIX_PAIR_EN
         pop_n = o_prefixed ? cnt_t'(2) : cnt_t'(1);
`else
         pop_n = cnt_t'(1);
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         inflight <= '0;
         drop     <= '0;
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
      end else begin
         inflight <= inflight_nxt;
         if (i_redirect) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            drop     <= inflight_nxt;
            fetch_pc <= {i_redirect_pc[0:61], 2'b00};
            resp_pc  <= {i_redirect_pc[0:61], 2'b00};
         end else begin
            if (ack_fire)
               fetch_pc <= fetch_pc + 64'd4;
            if (resp && (drop != '0))
               drop <= drop - cnt_t'(1);
            if (push) begin
               tail    <= tail + 1'b1;
               resp_pc <= resp_pc + 64'd4;
            end
            if (pop)
               head <= head + pop_n[PW-1:0];
            count <= count + cnt_t'(push) - pop_n;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         instr_mem[tail] <= i_mem_rdata;
         pc_mem[tail]    <= resp_pc;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && push && !pop)
         assert (count != DEPTH_C);
   end

`ifdef FETCH_PREFIX_PAIR_EN
   logic          head_pfx;
   logic [PW-1:0] head_nxt;
   assign head_nxt = head + 1'b1;
   assign head_pfx = (instr_mem[head][0:5] == 6'b000001);
`endif

   always_comb begin
      o_en           = 1'b0;
      o_instr        = '0;
      o_instr_pc     = '0;
      o_instr_suffix = '0;
      o_prefixed     = 1'b0;
      if (count != '0) begin
         o_instr    = instr_mem[head];
         o_instr_pc = pc_mem[head];
`ifdef FETCH_PREFIX_PAIR_EN
         // A prefix waits for its suffix word so the pair leaves together.
         if (head_pfx) begin
            if (count >= cnt_t'(2)) begin
               o_en           = 1'b1;
               o_prefixed     = 1'b1;
               o_instr_suffix = instr_mem[head_nxt];
            end
         end else begin
            o_en = 1'b1;
         end
`else
         o_en = 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic against an epoch-tagged
// memory/queue reference model.
module tb_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        o_mem_req;
   logic [0:63] o_mem_addr;
   logic        i_mem_ack = 1'b0;
   logic        i_mem_rvalid = 1'b0;
   logic [0:31] i_mem_rdata = '0;
   logic        i_redirect = 1'b0;
   logic [0:63] i_redirect_pc = '0;
   logic        o_en;
   logic [0:31] o_instr;
   logic [0:63] o_instr_pc;
   logic [0:31] o_instr_suffix;
   logic        o_prefixed;
   logic        i_stall = 1'b0;
   logic [$clog2(DEPTH):0] o_count;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
      .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
      .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
      .o_en(o_en), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
      .o_instr_suffix(o_instr_suffix), .o_prefixed(o_prefixed),
      .i_stall(i_stall), .o_count(o_count)
   );

   always #5 i_clk = ~i_clk;

   typedef struct { logic [63:0] addr; int epoch; } req_t;
   typedef struct { logic [31:0] instr; logic [63:0] pc; } ent_t;

   req_t        memq[$];
   ent_t        q[$];
   logic [63:0] mpc;
   int          epoch;
   logic [31:0] ovr [logic [63:0]];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] word_at(input logic [63:0] a);
      if (ovr.exists(a)) return ovr[a];
      return {1'b1, a[32:2] ^ (a[62:32] * 31'd7) ^ 31'h2A5F1C3D};
   endfunction

   function automatic bit is_pfx(input logic [31:0] w);
`ifdef FETCH_PREFIX_PAIR_EN
      return w[31:26] == 6'b000001;
`else
      return 1'b0 & w[0];
`endif
   endfunction

   function automatic bit model_en();
      if (q.size() == 0) return 1'b0;
      if (is_pfx(q[0].instr)) return q.size() >= 2;
      return 1'b1;
   endfunction

   // One clock of stimulus; the model advances by what the spec says this cycle's events do.
   task automatic cycle(input bit redir, input logic [63:0] rpc, input bit stall,
                        input bit ack_en, input bit rv_en, input bit ack_force,
                        input bit rv_force, output bit req, output logic [63:0] addr);
      int npop;
      bit acked;
      req_t r;
      i_mem_ack = 1'b0;
      i_redirect = redir;
      i_redirect_pc = rpc;
      i_stall = stall;
      i_mem_rvalid = 1'b0;
      i_mem_rdata = '0;
      if (rv_en && memq.size() > 0) begin
         i_mem_rvalid = 1'b1;
         i_mem_rdata = word_at(memq[0].addr);
      end else if (rv_force) begin
         i_mem_rvalid = 1'b1;
         i_mem_rdata = 32'hDEADBEEF;
      end
      #1;
      req = o_mem_req;
      addr = o_mem_addr;
      i_mem_ack = ack_en && (o_mem_req || ack_force);
      acked = i_mem_ack && (q.size() + memq.size() < DEPTH);
      npop = 0;
      if (!stall && model_en()) npop = is_pfx(q[0].instr) ? 2 : 1;
      if (redir) begin
         if (i_mem_rvalid && memq.size() > 0) r = memq.pop_front();
         if (acked) memq.push_back('{mpc, epoch});
         q.delete();
         epoch++;
         mpc = rpc & ~64'h3;
      end else begin
         for (int k = 0; k < npop; k++) void'(q.pop_front());
         if (i_mem_rvalid && memq.size() > 0) begin
            r = memq.pop_front();
            if (r.epoch == epoch) q.push_back('{word_at(r.addr), r.addr});
         end
         if (acked) begin
            memq.push_back('{mpc, epoch});
            mpc = mpc + 64'd4;
         end
      end
      @(posedge i_clk);
      #1;
      i_mem_ack = 1'b0;
      i_mem_rvalid = 1'b0;
      i_redirect = 1'b0;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_mem_ack = 1'b0; i_mem_rvalid = 1'b0; i_redirect = 1'b0; i_stall = 1'b0;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      memq.delete(); q.delete(); mpc = RESET_PC; epoch = 0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      checks += 8;
      if (o_mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", o_mem_req); end
      if (o_mem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", o_mem_addr, RESET_PC); end
      if (o_en !== 1'b0) begin errors++; $display("FAIL reset_en got %0b want 0", o_en); end
      if (o_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", o_instr); end
      if (o_instr_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", o_instr_pc); end
      if (o_instr_suffix !== 32'h0) begin errors++; $display("FAIL reset_suffix got %h want 0", o_instr_suffix); end
      if (o_prefixed !== 1'b0) begin errors++; $display("FAIL reset_prefixed got %0b want 0", o_prefixed); end
      if (o_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", o_count); end
      i_rst = 1'b0;
      #1;
      checks++;
      if (o_mem_req !== 1'b1) begin errors++; $display("FAIL reset_release_req got %0b want 1", o_mem_req); end
   endtask

   task automatic test_first_word();
      bit req; logic [63:0] addr;
      do_reset();
      ovr[64'h0] = 32'h48032BFB;
      cycle(0, '0, 1, 1, 0, 0, 0, req, addr);
      checks += 2;
      if (!(req && addr == 64'h0)) begin errors++; $display("FAIL first_req got req=%0b addr=%h want 1/0", req, addr); end
      if (o_en !== 1'b0) begin errors++; $display("FAIL first_en_early got %0b want 0", o_en); end
      cycle(0, '0, 1, 1, 1, 0, 0, req, addr);
      checks += 4;
      if (addr !== 64'h4) begin errors++; $display("FAIL first_next_addr got %h want 4", addr); end
      if (o_en !== 1'b1) begin errors++; $display("FAIL first_en got %0b want 1", o_en); end
      if (o_instr !== 32'h48032BFB) begin errors++; $display("FAIL first_instr got %h want 48032bfb", o_instr); end
      if (o_instr_pc !== 64'h0) begin errors++; $display("FAIL first_pc got %h want 0", o_instr_pc); end
   endtask

   task automatic test_stall_fill();
      bit req, seen; logic [63:0] addr, first;
      int nreq;
      do_reset();
      nreq = 0;
      for (int i = 0; i < 3 * DEPTH; i++) begin
         cycle(0, '0, 1, 1, 1, 0, 0, req, addr);
         if (req) nreq++;
      end
      checks += 3;
      if (nreq != DEPTH) begin errors++; $display("FAIL fill_reqs got %0d want %0d", nreq, DEPTH); end
      if (o_count !== DEPTH) begin errors++; $display("FAIL fill_count got %0d want %0d", o_count, DEPTH); end
      if (o_mem_req !== 1'b0) begin errors++; $display("FAIL fill_req_off got %0b want 0", o_mem_req); end
      seen = 0; first = '1;
      for (int k = 0; k < 2 * DEPTH; k++) begin
         checks += 2;
         if (o_en !== 1'b1) begin errors++; $display("FAIL drain_en[%0d] got %0b want 1", k, o_en); end
         if (o_instr_pc !== 64'(4 * k)) begin errors++; $display("FAIL drain_pc[%0d] got %h want %h", k, o_instr_pc, 64'(4 * k)); end
         cycle(0, '0, 0, 1, 1, 0, 0, req, addr);
         if (req && !seen) begin seen = 1; first = addr; end
      end
      checks++;
      if (first !== 64'(4 * DEPTH)) begin errors++; $display("FAIL resume_addr got %h want %h", first, 64'(4 * DEPTH)); end
   endtask

   task automatic test_redirect();
      bit req, seen; logic [63:0] addr, first;
      int n;
      do_reset();
      cycle(0, '0, 1, 1, 0, 0, 0, req, addr);
      cycle(0, '0, 1, 1, 0, 0, 0, req, addr);
      cycle(1, 64'h1003, 1, 0, 0, 0, 0, req, addr);
      checks += 2;
      if (req !== 1'b0) begin errors++; $display("FAIL redir_req got %0b want 0", req); end
      if (o_en !== 1'b0) begin errors++; $display("FAIL redir_en got %0b want 0", o_en); end
      n = -1; seen = 0; first = '1;
      for (int i = 1; i <= 12; i++) begin
         cycle(0, '0, 1, 1, 1, 0, 0, req, addr);
         if (req && !seen) begin seen = 1; first = addr; end
         if (o_en) begin n = i; break; end
      end
      checks += 4;
      if (first !== 64'h1000) begin errors++; $display("FAIL redir_addr got %h want 1000", first); end
      if (n != 3) begin errors++; $display("FAIL redir_latency got %0d want 3", n); end
      if (o_instr_pc !== 64'h1000) begin errors++; $display("FAIL redir_pc got %h want 1000", o_instr_pc); end
      if (o_instr !== word_at(64'h1000)) begin errors++; $display("FAIL redir_instr got %h want %h", o_instr, word_at(64'h1000)); end
   endtask

   task automatic test_redirect_same_cycle();
      bit req; logic [63:0] addr;
      int n;
      do_reset();
      cycle(0, '0, 1, 1, 0, 0, 0, req, addr);
      cycle(0, '0, 1, 1, 0, 0, 0, req, addr);
      cycle(1, 64'h200, 1, 1, 1, 1, 0, req, addr);
      checks += 2;
      if (o_en !== 1'b0) begin errors++; $display("FAIL same_en got %0b want 0", o_en); end
      if (o_count !== '0) begin errors++; $display("FAIL same_count got %0d want 0", o_count); end
      n = -1;
      for (int i = 1; i <= 12; i++) begin
         cycle(0, '0, 1, 1, 1, 0, 0, req, addr);
         if (o_en) begin n = i; break; end
      end
      checks += 3;
      if (n != 3) begin errors++; $display("FAIL same_latency got %0d want 3", n); end
      if (o_instr_pc !== 64'h200) begin errors++; $display("FAIL same_pc got %h want 200", o_instr_pc); end
      if (o_instr !== word_at(64'h200)) begin errors++; $display("FAIL same_instr got %h want %h", o_instr, word_at(64'h200)); end
   endtask

   task automatic test_reset_midflight();
      bit req; logic [63:0] addr;
      do_reset();
      for (int i = 0; i < DEPTH; i++) cycle(0, '0, 1, 1, 1, 0, 0, req, addr);
      checks++;
      if (o_count !== DEPTH - 1) begin errors++; $display("FAIL mid_count got %0d want %0d", o_count, DEPTH - 1); end
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      checks += 4;
      if (o_en !== 1'b0) begin errors++; $display("FAIL mid_rst_en got %0b want 0", o_en); end
      if (o_count !== '0) begin errors++; $display("FAIL mid_rst_count got %0d want 0", o_count); end
      if (o_mem_addr !== RESET_PC) begin errors++; $display("FAIL mid_rst_addr got %h want %h", o_mem_addr, RESET_PC); end
      if (o_instr !== 32'h0 || o_instr_pc !== 64'h0) begin errors++; $display("FAIL mid_rst_head got %h/%h want 0/0", o_instr, o_instr_pc); end
      i_rst = 1'b0;
      memq.delete(); q.delete(); mpc = RESET_PC; epoch = 0;
      cycle(0, '0, 1, 0, 0, 0, 1, req, addr);
      checks += 2;
      if (o_en !== 1'b0) begin errors++; $display("FAIL late_rvalid_en got %0b want 0", o_en); end
      if (o_count !== '0) begin errors++; $display("FAIL late_rvalid_count got %0d want 0", o_count); end
   endtask

`ifdef FETCH_PREFIX_PAIR_EN
   task automatic test_prefix();
      bit req; logic [63:0] addr;
      do_reset();
      ovr[64'h0] = 32'h04000000;
      ovr[64'h4] = 32'h38600001;
      cycle(0, '0, 1, 1, 0, 0, 0, req, addr);
      cycle(0, '0, 1, 1, 1, 0, 0, req, addr);
      checks++;
      if (o_en !== 1'b0) begin errors++; $display("FAIL pfx_lone_en got %0b want 0", o_en); end
      cycle(0, '0, 1, 0, 1, 0, 0, req, addr);
      checks += 4;
      if (o_en !== 1'b1 || o_prefixed !== 1'b1) begin errors++; $display("FAIL pfx_pair en=%0b pfx=%0b want 1/1", o_en, o_prefixed); end
      if (o_instr !== 32'h04000000) begin errors++; $display("FAIL pfx_instr got %h want 04000000", o_instr); end
      if (o_instr_suffix !== 32'h38600001) begin errors++; $display("FAIL pfx_suffix got %h want 38600001", o_instr_suffix); end
      if (o_count !== 2) begin errors++; $display("FAIL pfx_count got %0d want 2", o_count); end
      cycle(0, '0, 0, 0, 0, 0, 0, req, addr);
      checks++;
      if (o_count !== 0) begin errors++; $display("FAIL pfx_pop_count got %0d want 0", o_count); end
   endtask
`endif

   task automatic test_random();
      bit req, exp_req, redir, stall, ack, rv;
      logic [63:0] addr, exp_addr, rpc;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         checks += 5;
         if (o_en !== model_en()) begin errors++; $display("FAIL rand_en c%0d got %0b want %0b", c, o_en, model_en()); end
         if (o_count !== q.size()) begin errors++; $display("FAIL rand_count c%0d got %0d want %0d", c, o_count, q.size()); end
         if (q.size() > 0) begin
            if (o_instr !== q[0].instr) begin errors++; $display("FAIL rand_instr c%0d got %h want %h", c, o_instr, q[0].instr); end
            if (o_instr_pc !== q[0].pc) begin errors++; $display("FAIL rand_pc c%0d got %h want %h", c, o_instr_pc, q[0].pc); end
         end else begin
            if (o_instr !== 32'h0) begin errors++; $display("FAIL rand_instr c%0d got %h want 0", c, o_instr); end
            if (o_instr_pc !== 64'h0) begin errors++; $display("FAIL rand_pc c%0d got %h want 0", c, o_instr_pc); end
         end
         if (o_prefixed !== 1'b0 || o_instr_suffix !== 32'h0) begin errors++; $display("FAIL rand_pfx c%0d got %0b/%h want 0/0", c, o_prefixed, o_instr_suffix); end
         redir = ($urandom_range(99) < 3);
         rpc = ($urandom_range(3) == 0) ? 64'hFFFFFFFFFFFFFFF5 : {$urandom, $urandom};
         stall = ($urandom_range(99) < 40);
         ack = ($urandom_range(99) < 70);
         rv = ($urandom_range(99) < 60);
         exp_req = !redir && (q.size() + memq.size() < DEPTH);
         exp_addr = mpc;
         cycle(redir, rpc, stall, ack, rv, 0, 0, req, addr);
         checks++;
         if (req !== exp_req) begin errors++; $display("FAIL rand_req c%0d got %0b want %0b", c, req, exp_req); end
         if (exp_req) begin
            checks++;
            if (addr !== exp_addr) begin errors++; $display("FAIL rand_addr c%0d got %h want %h", c, addr, exp_addr); end
         end
      end
   endtask

   initial begin
      mpc = RESET_PC;
      epoch = 0;
      test_reset();
      test_first_word();
      test_stall_fill();
      test_redirect();
      test_redirect_same_cycle();
      test_reset_midflight();
`ifdef FETCH_PREFIX_PAIR_EN
      test_prefix();
`endif
      ovr.delete();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
